bios_wdt_timer: RTL and testbench



---
 rtl/bios_wdt_timer.sv | 167 ++++++++++++++++
 tb/tb_bios_wdt_timer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bios_wdt_timer.sv
// BIOS watchdog timer: turns toggle-per-write events into arm/kick/disarm commands and counts down a
// seconds-based timeout. Define BIOS_WDT_ERRCNT_EN to build the saturating sequence-error counter.
module bios_wdt_timer #(
    parameter logic [7:0]  TIMEOUT_SEC = 8'd180,
    parameter logic [14:0] PRESCALE    = 15'd32767
) (
    input  logic       CLK32768,
    input  logic       MainResetN,
    input  logic [4:0] bCPUWrWdtRegSig,
    output logic       BiosWdtArmed,
    output logic       BiosWdtExpired,
    output logic       BiosWdtTimeoutPulse,
    output logic [7:0] BiosWdtCnt,
    output logic [3:0] BiosWdtErrCnt
);

    localparam int unsigned SigW = 5;
    localparam int unsigned CntW = 8;
    localparam int unsigned PreW = 15;
    localparam int unsigned ErrW = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        UNLOCK  = 2'd2,
        EXPIRED = 2'd3
    } wdtState_t;

    wdtState_t       state;
    wdtState_t       stateNext;
    wdtState_t       evtState;
    logic [SigW-1:0] sigD;
    logic [SigW-1:0] evt;
    logic            evtAny;
    logic            evtMulti;
    logic            e55;
    logic            e29;
    logic            eFF;
    logic            eAA;
    logic            eOther;
    logic [PreW-1:0] presc;
    logic [PreW-1:0] prescNext;
    logic [CntW-1:0] cntNext;
    logic            tick;
    logic            running;
    logic            doReload;
    logic            doDisarm;
    logic            armedNext;
    logic            expiredNext;
    logic            pulseNext;

    // Edge detect; more than one toggled bit collapses into an OTHER event
    always_comb begin
        evt      = bCPUWrWdtRegSig ^ sigD;
        evtAny   = |evt;
        evtMulti = |(evt & (evt - SigW'(1)));
        e55      = !evtMulti && evt[0];
        e29      = !evtMulti && evt[1];
        eFF      = !evtMulti && evt[2];
        eAA      = !evtMulti && evt[3];
        eOther   = evtMulti || (evtAny && evt[4]);
    end

    // Next state; reload and disarm take priority over an expiring tick
    always_comb begin
        stateNext = state;
        evtState  = state;
        cntNext   = BiosWdtCnt;
        prescNext = presc;
        doReload  = 1'b0;
        doDisarm  = 1'b0;
        running   = (state == ARMED) || (state == UNLOCK);
        tick      = (presc == PRESCALE);

        case (state)
            IDLE: begin
                doReload = e29;
            end
            ARMED: begin
                doReload = e29;
                if (e55) begin
                    evtState = UNLOCK;
                end
            end
            UNLOCK: begin
                doReload = eAA;
                doDisarm = eFF;
                if (e29 || eOther) begin
                    evtState = ARMED;
                end
            end
            default: begin
            end
        endcase

        if (doReload) begin
            stateNext = ARMED;
            cntNext   = TIMEOUT_SEC;
            prescNext = '0;
        end else if (doDisarm) begin
            stateNext = IDLE;
            cntNext   = '0;
            prescNext = '0;
        end else if (running) begin
            stateNext = evtState;
            if (tick) begin
                prescNext = '0;
                // A count of 0 here is unreachable for legal TIMEOUT_SEC; treat it as expiry so it never wraps
                if (BiosWdtCnt <= CntW'(1)) begin
                    stateNext = EXPIRED;
                    cntNext   = '0;
                end else begin
                    cntNext = BiosWdtCnt - CntW'(1);
                end
            end else begin
                prescNext = presc + PreW'(1);
            end
        end

        armedNext   = (stateNext == ARMED) || (stateNext == UNLOCK);
        expiredNext = (stateNext == EXPIRED);
        pulseNext   = expiredNext && (state != EXPIRED);
    end

    // State, counters and registered status outputs
    always_ff @(posedge CLK32768 or negedge MainResetN) begin
        if (!MainResetN) begin
            state               <= IDLE;
            sigD                <= '0;
            presc               <= '0;
            BiosWdtCnt          <= '0;
            BiosWdtArmed        <= 1'b0;
            BiosWdtExpired      <= 1'b0;
            BiosWdtTimeoutPulse <= 1'b0;
        end else begin
            state               <= stateNext;
            sigD                <= bCPUWrWdtRegSig;
            presc               <= prescNext;
            BiosWdtCnt          <= cntNext;
            BiosWdtArmed        <= armedNext;
            BiosWdtExpired      <= expiredNext;
            BiosWdtTimeoutPulse <= pulseNext;
        end
    end

`ifdef BIOS_WDT_ERRCNT_EN
    logic errEvt;

    // Out-of-sequence writes while armed or unlocked
    always_comb begin
        errEvt = ((state == ARMED) && (eFF || eAA || eOther)) ||
                 ((state == UNLOCK) && (e29 || eOther));
    end

    // Saturating error count; survives disarm, cleared only by reset
    always_ff @(posedge CLK32768 or negedge MainResetN) begin
        if (!MainResetN) begin
            BiosWdtErrCnt <= '0;
        end else if (errEvt && (BiosWdtErrCnt != '1)) begin
            BiosWdtErrCnt <= BiosWdtErrCnt + ErrW'(1);
        end
    end
`else
    assign BiosWdtErrCnt = ErrW'(0);
`endif

endmodule

// File: tb/tb_bios_wdt_timer.sv
// Scoreboard bench for bios_wdt_timer: a time-based reference model predicts every cycle's outputs,
// a separate monitor compares them against the DUT.
module tb_bios_wdt_timer;

    localparam int T   = 2;
    localparam int P   = 3;
    localparam int PER = P + 1;

    logic       CLK32768 = 1'b0;
    logic       MainResetN = 1'b0;
    logic [4:0] bCPUWrWdtRegSig = 5'd0;
    logic       BiosWdtArmed;
    logic       BiosWdtExpired;
    logic       BiosWdtTimeoutPulse;
    logic [7:0] BiosWdtCnt;
    logic [3:0] BiosWdtErrCnt;

    bios_wdt_timer #(
        .TIMEOUT_SEC(8'd2),
        .PRESCALE   (15'd3)
    ) dut (
        .CLK32768           (CLK32768),
        .MainResetN         (MainResetN),
        .bCPUWrWdtRegSig    (bCPUWrWdtRegSig),
        .BiosWdtArmed       (BiosWdtArmed),
        .BiosWdtExpired     (BiosWdtExpired),
        .BiosWdtTimeoutPulse(BiosWdtTimeoutPulse),
        .BiosWdtCnt         (BiosWdtCnt),
        .BiosWdtErrCnt      (BiosWdtErrCnt)
    );

    always #5 CLK32768 = ~CLK32768;

    // Reference model: mode 0 idle, 1 armed, 2 unlocked, 3 expired; count derived from time since arm/kick
    int         mMode = 0;
    int         mArmAt = 0;
    int         mNow = 0;
    int         mErr = 0;
    bit         mPulse = 1'b0;
    logic [4:0] mSigSeen = 5'd0;

    logic [14:0] expQ[$];
    int          errors = 0;
    int          checks = 0;
    bit          probeReq = 1'b0;
    bit          probeAck = 1'b0;
    bit          doneReq = 1'b0;

    function automatic void modelReset();
        mMode    = 0;
        mErr     = 0;
        mPulse   = 1'b0;
        mSigSeen = 5'd0;
    endfunction

    function automatic void modelEdge();
        logic [4:0] ev;
        int  kind;
        bit  expiring;
        bit  reload;
        bit  disarm;
        bit  err;
        ev     = bCPUWrWdtRegSig ^ mSigSeen;
        mNow   = mNow + 1;
        mPulse = 1'b0;
        if (!MainResetN) begin
            modelReset();
            return;
        end
        mSigSeen = bCPUWrWdtRegSig;
        // kind: 0 none, 1 0x55, 2 0x29, 3 0xFF, 4 0xAA, 5 other
        if (ev == 5'd0)                          kind = 0;
        else if ($countones(ev) > 1 || ev[4])    kind = 5;
        else if (ev[0])                          kind = 1;
        else if (ev[1])                          kind = 2;
        else if (ev[2])                          kind = 3;
        else                                     kind = 4;
        if (mMode == 3) return;
        expiring = (mMode == 1 || mMode == 2) && (mNow - mArmAt == T * PER);
        reload   = (kind == 2 && mMode != 2) || (kind == 4 && mMode == 2);
        disarm   = (kind == 3 && mMode == 2);
        err      = (mMode == 1 && kind >= 3) || (mMode == 2 && (kind == 2 || kind == 5));
        if (err && mErr < 15) mErr = mErr + 1;
        if (reload) begin
            mMode  = 1;
            mArmAt = mNow;
        end else if (disarm) begin
            mMode = 0;
        end else if (expiring) begin
            mMode  = 3;
            mPulse = 1'b1;
        end else if (mMode == 1 && kind == 1) begin
            mMode = 2;
        end else if (mMode == 2 && err) begin
            mMode = 1;
        end
    endfunction

    function automatic logic [14:0] modelOut();
        logic [7:0] c;
        logic [3:0] e;
        bit         live;
        live = (mMode == 1 || mMode == 2);
        c = live ? 8'(T - (mNow - mArmAt) / PER) : 8'd0;
`ifdef BIOS_WDT_ERRCNT_EN
        e = 4'(mErr);
`else
        e = 4'd0;
`endif
        return {live, mMode == 3, mPulse, c, e};
    endfunction

    task automatic step(input logic [4:0] nextSig, input logic nextRst);
        @(posedge CLK32768);
        modelEdge();
        expQ.push_back(modelOut());
        #1;
        bCPUWrWdtRegSig = nextSig;
        MainResetN      = nextRst;
    endtask

    task automatic tog(input logic [4:0] mask);
        step(bCPUWrWdtRegSig ^ mask, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) step(bCPUWrWdtRegSig, 1'b1);
    endtask

    // Async reset mid-cycle; the decoder upstream resets alongside, so its toggles return to 0
    task automatic pulseReset();
        @(negedge CLK32768);
        #2;
        MainResetN      = 1'b0;
        bCPUWrWdtRegSig = 5'd0;
        modelReset();
        #1;
        probeReq = ~probeReq;
    endtask

    // Monitor: pops one prediction per cycle, also handles the immediate-reset probe and the end check
    initial begin : monitor
        logic [14:0] want;
        logic [14:0] got;
        forever begin
            @(negedge CLK32768 or probeReq or doneReq);
            got = {BiosWdtArmed, BiosWdtExpired, BiosWdtTimeoutPulse, BiosWdtCnt, BiosWdtErrCnt};
            if (doneReq) begin
                checks = checks + 1;
                if (expQ.size() != 0) begin
                    errors = errors + 1;
                    $display("FAIL drain: %0d predictions never compared, required 0", expQ.size());
                end
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end else if (probeReq != probeAck) begin
                probeAck = probeReq;
                checks   = checks + 1;
                if (got !== 15'd0) begin
                    errors = errors + 1;
                    $display("FAIL async_reset t=%0t: got arm=%b exp=%b pulse=%b cnt=%0d err=%0d, required all 0",
                             $time, got[14], got[13], got[12], got[11:4], got[3:0]);
                end
            end else if (expQ.size() > 0) begin
                want   = expQ.pop_front();
                checks = checks + 1;
                if (got !== want) begin
                    errors = errors + 1;
                    $display("FAIL cycle_out t=%0t: got arm=%b exp=%b pulse=%b cnt=%0d err=%0d, required arm=%b exp=%b pulse=%b cnt=%0d err=%0d",
                             $time, got[14], got[13], got[12], got[11:4], got[3:0],
                             want[14], want[13], want[12], want[11:4], want[3:0]);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        logic [4:0] masks [8];
        logic [4:0] m;
        int         r;
        masks = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd16, 5'd1, 5'd8, 5'd2};

        // Reset state
        repeat (3) step(5'd0, 1'b0);
        step(5'd0, 1'b1);

        // Arm and expire, then async reset while expired and re-arm
        tog(5'd2);
        idle(12);
        pulseReset();
        tog(5'd2);
        idle(4);

        // Kick after 6 cycles
        pulseReset();
        tog(5'd2);
        idle(5);
        tog(5'd1);
        tog(5'd8);
        idle(12);

        // Disarm
        pulseReset();
        tog(5'd2);
        tog(5'd1);
        tog(5'd4);
        idle(20);

        // Bad sequence in UNLOCK
        pulseReset();
        tog(5'd2);
        tog(5'd1);
        tog(5'd16);
        idle(10);

        // Simultaneous 0x55 + 0xAA while armed
        pulseReset();
        tog(5'd2);
        idle(2);
        tog(5'd9);
        idle(10);

        // Kick from UNLOCK landing on the expiring tick
        pulseReset();
        tog(5'd2);
        tog(5'd1);
        idle(6);
        tog(5'd8);
        idle(10);

        // Re-arm in ARMED landing on the expiring tick
        pulseReset();
        tog(5'd2);
        idle(7);
        tog(5'd2);
        idle(10);

        // Disarm landing on the expiring tick
        pulseReset();
        tog(5'd2);
        tog(5'd1);
        idle(6);
        tog(5'd4);
        idle(10);

        // Error counter saturation: 17 OTHER writes kept armed by periodic re-arms
        pulseReset();
        tog(5'd2);
        for (int i = 0; i < 17; i++) begin
            tog(5'd16);
            if (i % 3 == 2) tog(5'd2);
        end
        idle(3);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                pulseReset();
            end else if (r < 8) begin
                m = 5'($urandom_range(3, 31));
                tog(m);
            end else if (r < 45) begin
                tog(masks[$urandom_range(0, 7)]);
            end else begin
                idle(1);
            end
        end
        idle(3);

        @(negedge CLK32768);
        @(negedge CLK32768);
        #2;
        doneReq = 1'b1;
    end

endmodule
